// File: rtl/mem_lsu_axi.sv
// MEM-stage load/store unit: one AXI4-Lite read or write per memory instruction,
// load data alignment/extension, EX/MEM hold via mem_en. Optional ALIGN_CHK_EN macro.
module mem_lsu_axi (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr_i,
    input  logic [63:0] rd_data_i,
    input  logic        rd_wen_i,
    input  logic        read_ram_i,
    input  logic        write_ram_i,
    input  logic [31:0] inst_i,
    input  logic [63:0] inst_addr_i,
    input  logic [31:0] id_axi_araddr_i,
    input  logic [63:0] op2_i,
    output logic        mem_en,
    output logic [4:0]  rd_addr_o,
    output logic [63:0] rd_data_o,
    output logic        rd_wen_o,
    output logic [31:0] inst_o,
    output logic [63:0] inst_addr_o,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [63:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [63:0] axi_wdata,
    output logic [7:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    output logic        bus_err_o,
    output logic        misalign_o
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned SW   = 8;

    typedef enum logic [2:0] {IDLE, AR, R, W, B, DONE} state_t;

    state_t            state;
    logic              ar_q, r_q, aw_q, w_q, b_q;
    logic              err_q, mis_q, is_load_q;
    logic [XLEN-1:0]   ld_q;

    logic [2:0]        funct3;
    logic [5:0]        sh;
    logic [XLEN-1:0]   rshift;
    logic [XLEN-1:0]   load_ext;
    logic [SW-1:0]     strb_base;
    logic              mem_req;
    logic              busy;
    logic              misaligned;

    assign funct3  = inst_i[14:12];
    assign sh      = {id_axi_araddr_i[2:0], 3'b000};
    assign rshift  = axi_rdata >> sh;
    assign mem_req = read_ram_i | write_ram_i;
    assign busy    = (state == AR) || (state == R) || (state == W) || (state == B);

    // Shift the beat down to the addressed byte, then extend by access width/sign.
    always_comb begin
        load_ext = rshift;
        case (funct3)
            3'b000:  load_ext = {{56{rshift[7]}},  rshift[7:0]};
            3'b001:  load_ext = {{48{rshift[15]}}, rshift[15:0]};
            3'b010:  load_ext = {{32{rshift[31]}}, rshift[31:0]};
            3'b100:  load_ext = {56'd0, rshift[7:0]};
            3'b101:  load_ext = {48'd0, rshift[15:0]};
            3'b110:  load_ext = {32'd0, rshift[31:0]};
            default: load_ext = rshift;
        endcase
    end

    always_comb begin
        strb_base = 8'hFF;
        case (funct3[1:0])
            2'b00:   strb_base = 8'h01;
            2'b01:   strb_base = 8'h03;
            2'b10:   strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

`ifdef ALIGN_CHK_EN
    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = id_axi_araddr_i[0];
            2'b10:   misaligned = |id_axi_araddr_i[1:0];
            2'b11:   misaligned = |id_axi_araddr_i[2:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ar_q      <= 1'b0;
            r_q       <= 1'b0;
            aw_q      <= 1'b0;
            w_q       <= 1'b0;
            b_q       <= 1'b0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            is_load_q <= 1'b0;
            ld_q      <= '0;
        end else begin
            err_q <= 1'b0;
            mis_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        is_load_q <= read_ram_i;
                        if (misaligned) begin
                            mis_q <= 1'b1;
                            state <= DONE;
                        end else if (read_ram_i) begin
                            ar_q  <= 1'b1;
                            state <= AR;
                        end else begin
                            aw_q  <= 1'b1;
                            w_q   <= 1'b1;
                            state <= W;
                        end
                    end
                end
                AR: begin
                    if (axi_arready) begin
                        ar_q  <= 1'b0;
                        r_q   <= 1'b1;
                        state <= R;
                    end
                end
                R: begin
                    if (axi_rvalid) begin
                        r_q   <= 1'b0;
                        ld_q  <= load_ext;
                        err_q <= |axi_rresp;
                        state <= DONE;
                    end
                end
                W: begin
                    // Address and data handshakes complete independently, in any order.
                    if (aw_q && axi_awready) aw_q <= 1'b0;
                    if (w_q && axi_wready)   w_q  <= 1'b0;
                    if ((!aw_q || axi_awready) && (!w_q || axi_wready)) begin
                        b_q   <= 1'b1;
                        state <= B;
                    end
                end
                B: begin
                    if (axi_bvalid) begin
                        b_q   <= 1'b0;
                        err_q <= |axi_bresp;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign axi_arvalid = ar_q;
    assign axi_rready  = r_q;
    assign axi_awvalid = aw_q;
    assign axi_wvalid  = w_q;
    assign axi_bready  = b_q;
    assign axi_araddr  = {id_axi_araddr_i[31:3], 3'b000};
    assign axi_awaddr  = {id_axi_araddr_i[31:3], 3'b000};
    assign axi_wdata   = op2_i << sh;
    assign axi_wstrb   = SW'(strb_base << id_axi_araddr_i[2:0]);
    assign bus_err_o   = err_q;
    assign misalign_o  = mis_q;

    // Hold drops with reset so the EX/MEM register is released during an abort.
    assign mem_en = rst & (busy | ((state == IDLE) & mem_req));

    assign rd_addr_o   = rd_addr_i;
    assign inst_o      = inst_i;
    assign inst_addr_o = inst_addr_i;
    assign rd_data_o   = (state == DONE && is_load_q) ? ld_q : rd_data_i;

    // Write-back only for plain ops in IDLE and for clean loads in DONE.
    always_comb begin
        rd_wen_o = 1'b0;
        if (state == IDLE)
            rd_wen_o = rd_wen_i & ~mem_req;
        else if (state == DONE)
            rd_wen_o = rd_wen_i & is_load_q & ~err_q & ~mis_q;
    end
endmodule

// File: tb/tb_mem_lsu_axi.sv
// Directed self-checking bench for mem_lsu_axi; define ALIGN_CHK_EN to exercise the alignment check.
module tb_mem_lsu_axi;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic [63:0] rd_data_i;
    logic        rd_wen_i;
    logic        read_ram_i, write_ram_i;
    logic [31:0] inst_i;
    logic [63:0] inst_addr_i;
    logic [31:0] id_axi_araddr_i;
    logic [63:0] op2_i;
    logic        mem_en;
    logic [4:0]  rd_addr_o;
    logic [63:0] rd_data_o;
    logic        rd_wen_o;
    logic [31:0] inst_o;
    logic [63:0] inst_addr_o;
    logic [31:0] axi_araddr;
    logic        axi_arvalid, axi_arready;
    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid, axi_awready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wvalid, axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid, axi_bready;
    logic        bus_err_o, misalign_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_lsu_axi dut (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .rd_wen_i(rd_wen_i),
        .read_ram_i(read_ram_i), .write_ram_i(write_ram_i),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .id_axi_araddr_i(id_axi_araddr_i), .op2_i(op2_i),
        .mem_en(mem_en),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rd_addr_i = 5'd0; rd_data_i = '0; rd_wen_i = 1'b0;
        read_ram_i = 1'b0; write_ram_i = 1'b0;
        inst_i = '0; inst_addr_i = '0; id_axi_araddr_i = '0; op2_i = '0;
        axi_arready = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rvalid = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bresp = 2'b00; axi_bvalid = 1'b0;
    endtask

    // Load with immediate arready/rvalid; entered and left at posedge+1 in IDLE.
    task automatic set_load(input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] rdata, input logic [1:0] resp);
        read_ram_i = 1'b1; write_ram_i = 1'b0; rd_wen_i = 1'b1; rd_addr_i = 5'd10;
        inst_i = {17'd0, f3, 12'h003}; id_axi_araddr_i = addr;
        axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = rdata; axi_rresp = resp;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #12;
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
        n_cmp++; if ({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready} !== 5'b0) begin n_bad++;
            $display("FAIL reset_handshakes got %b want 00000", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}); end
        n_cmp++; if ({bus_err_o, misalign_o} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses got %b want 00", {bus_err_o, misalign_o}); end
        @(negedge clk) rst = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        rd_data_i = 64'h1234; rd_wen_i = 1'b1; rd_addr_i = 5'd7;
        inst_i = 32'h00b50533; inst_addr_i = 64'h8000_0040;
        #1;
        n_cmp++; if (rd_data_o !== 64'h1234) begin n_bad++; $display("FAIL add_data got %h want 1234", rd_data_o); end
        n_cmp++; if ({rd_wen_o, rd_addr_o} !== {1'b1, 5'd7}) begin n_bad++; $display("FAIL add_wen_addr got %b want 100111", {rd_wen_o, rd_addr_o}); end
        n_cmp++; if ({inst_o, inst_addr_o} !== {32'h00b50533, 64'h8000_0040}) begin n_bad++; $display("FAIL add_inst got %h want 00b50533", inst_o); end
        n_cmp++; if ({mem_en, axi_arvalid, axi_awvalid, axi_wvalid} !== 4'b0) begin n_bad++;
            $display("FAIL add_idle got %b want 0000", {mem_en, axi_arvalid, axi_awvalid, axi_wvalid}); end
        step();
        clear_inputs();
    endtask

    task automatic test_load_byte();
        set_load(3'b000, 32'h8000_0003, 64'h0000_0000_8000_0000, 2'b00);
        #1;
        n_cmp++; if ({mem_en, axi_arvalid, rd_wen_o} !== 3'b100) begin n_bad++; $display("FAIL lb_idle got %b want 100", {mem_en, axi_arvalid, rd_wen_o}); end
        step();
        n_cmp++; if ({mem_en, axi_arvalid, axi_rready} !== 3'b110) begin n_bad++; $display("FAIL lb_ar got %b want 110", {mem_en, axi_arvalid, axi_rready}); end
        n_cmp++; if (axi_araddr !== 32'h8000_0000) begin n_bad++; $display("FAIL lb_araddr got %h want 80000000", axi_araddr); end
        step();
        n_cmp++; if ({mem_en, axi_arvalid, axi_rready} !== 3'b101) begin n_bad++; $display("FAIL lb_r got %b want 101", {mem_en, axi_arvalid, axi_rready}); end
        step();
        n_cmp++; if (rd_data_o !== 64'hFFFF_FFFF_FFFF_FF80) begin n_bad++; $display("FAIL lb_data got %h want ffffffffffffff80", rd_data_o); end
        n_cmp++; if ({mem_en, rd_wen_o, bus_err_o, axi_rready} !== 4'b0100) begin n_bad++;
            $display("FAIL lb_done got %b want 0100", {mem_en, rd_wen_o, bus_err_o, axi_rready}); end
        step();
        clear_inputs();
    endtask

    task automatic test_store_half();
        write_ram_i = 1'b1; rd_wen_i = 1'b1; inst_i = {17'd0, 3'b001, 12'h023};
        id_axi_araddr_i = 32'h8000_0006; op2_i = 64'hABCD;
        axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1;
        step();
        n_cmp++; if ({mem_en, axi_awvalid, axi_wvalid} !== 3'b111) begin n_bad++; $display("FAIL sh_w got %b want 111", {mem_en, axi_awvalid, axi_wvalid}); end
        n_cmp++; if (axi_wstrb !== 8'hC0) begin n_bad++; $display("FAIL sh_wstrb got %h want c0", axi_wstrb); end
        n_cmp++; if (axi_wdata !== 64'hABCD_0000_0000_0000) begin n_bad++; $display("FAIL sh_wdata got %h want abcd000000000000", axi_wdata); end
        n_cmp++; if (axi_awaddr !== 32'h8000_0000) begin n_bad++; $display("FAIL sh_awaddr got %h want 80000000", axi_awaddr); end
        step();
        n_cmp++; if ({mem_en, axi_bready, axi_awvalid, axi_wvalid} !== 4'b1100) begin n_bad++;
            $display("FAIL sh_b got %b want 1100", {mem_en, axi_bready, axi_awvalid, axi_wvalid}); end
        step();
        n_cmp++; if ({mem_en, rd_wen_o, bus_err_o, axi_bready} !== 4'b0000) begin n_bad++;
            $display("FAIL sh_done got %b want 0000", {mem_en, rd_wen_o, bus_err_o, axi_bready}); end
        step();
        clear_inputs();
    endtask

    task automatic test_store_aw_delay();
        write_ram_i = 1'b1; inst_i = {17'd0, 3'b011, 12'h023};
        id_axi_araddr_i = 32'h8000_0008; op2_i = 64'h1122_3344_5566_7788;
        axi_awready = 1'b0; axi_wready = 1'b1; axi_bvalid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_cmp++; if ({mem_en, axi_awvalid, axi_wvalid, axi_bready} !== {2'b11, (c == 1), 1'b0}) begin n_bad++;
                $display("FAIL sd_w_cycle%0d got %b want 11%b0", c, {mem_en, axi_awvalid, axi_wvalid, axi_bready}, (c == 1)); end
            if (c == 1) begin
                n_cmp++; if ({axi_wstrb, axi_wdata} !== {8'hFF, 64'h1122_3344_5566_7788}) begin n_bad++;
                    $display("FAIL sd_wdata got %h/%h want ff/1122334455667788", axi_wstrb, axi_wdata); end
            end
        end
        axi_awready = 1'b1;
        step();
        n_cmp++; if ({mem_en, axi_awvalid, axi_bready} !== 3'b101) begin n_bad++; $display("FAIL sd_b got %b want 101", {mem_en, axi_awvalid, axi_bready}); end
        step();
        n_cmp++; if ({mem_en, rd_wen_o, axi_bready} !== 3'b000) begin n_bad++; $display("FAIL sd_done got %b want 000", {mem_en, rd_wen_o, axi_bready}); end
        step();
        clear_inputs();
    endtask

    task automatic test_bus_error();
        set_load(3'b010, 32'h8000_0004, 64'hDEAD_BEEF_0000_0000, 2'b10);
        step(); step(); step();
        n_cmp++; if ({bus_err_o, rd_wen_o, mem_en} !== 3'b100) begin n_bad++; $display("FAIL lw_err_done got %b want 100", {bus_err_o, rd_wen_o, mem_en}); end
        n_cmp++; if (rd_data_o !== 64'hFFFF_FFFF_DEAD_BEEF) begin n_bad++; $display("FAIL lw_err_data got %h want ffffffffdeadbeef", rd_data_o); end
        step();
        clear_inputs();
        #1;
        n_cmp++; if (bus_err_o !== 1'b0) begin n_bad++; $display("FAIL lw_err_pulse got %b want 0", bus_err_o); end
    endtask

    task automatic test_back_to_back();
        set_load(3'b011, 32'h8000_0010, 64'hCAFE_BABE_DEAD_BEEF, 2'b00);
        step(); step(); step();
        n_cmp++; if (rd_data_o !== 64'hCAFE_BABE_DEAD_BEEF) begin n_bad++; $display("FAIL ld_data got %h want cafebabedeadbeef", rd_data_o); end
        step();
        set_load(3'b100, 32'h8000_0017, 64'h9A00_0000_0000_0000, 2'b00);
        #1;
        n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got %b want 1", mem_en); end
        step();
        n_cmp++; if (axi_arvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_arvalid got %b want 1", axi_arvalid); end
        step(); step();
        n_cmp++; if ({rd_data_o, rd_wen_o} !== {64'h9A, 1'b1}) begin n_bad++; $display("FAIL lbu_data got %h/%b want 9a/1", rd_data_o, rd_wen_o); end
        step();
        clear_inputs();
    endtask

`ifdef ALIGN_CHK_EN
    task automatic test_misalign();
        set_load(3'b010, 32'h8000_0002, 64'h0123_4567_89AB_CDEF, 2'b00);
        #1;
        n_cmp++; if ({mem_en, axi_arvalid} !== 2'b10) begin n_bad++; $display("FAIL mis_idle got %b want 10", {mem_en, axi_arvalid}); end
        step();
        n_cmp++; if ({misalign_o, rd_wen_o, mem_en, axi_arvalid} !== 4'b1000) begin n_bad++;
            $display("FAIL mis_done got %b want 1000", {misalign_o, rd_wen_o, mem_en, axi_arvalid}); end
        step();
        clear_inputs();
        #1;
        n_cmp++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL mis_pulse got %b want 0", misalign_o); end
    endtask
`else
    task automatic test_misalign();
        set_load(3'b110, 32'h8000_0002, 64'h0123_4567_89AB_CDEF, 2'b00);
        step();
        n_cmp++; if ({axi_arvalid, axi_araddr} !== {1'b1, 32'h8000_0000}) begin n_bad++;
            $display("FAIL lwu_mis_ar got %b/%h want 1/80000000", axi_arvalid, axi_araddr); end
        step(); step();
        n_cmp++; if ({rd_data_o, misalign_o} !== {64'h4567_89AB, 1'b0}) begin n_bad++;
            $display("FAIL lwu_mis_data got %h/%b want 456789ab/0", rd_data_o, misalign_o); end
        step();
        clear_inputs();
    endtask
`endif

    task automatic test_reset_mid_read();
        set_load(3'b011, 32'h8000_0020, 64'h1, 2'b00);
        axi_rvalid = 1'b0;
        step(); step();
        n_cmp++; if ({axi_rready, mem_en} !== 2'b11) begin n_bad++; $display("FAIL rst_r_pre got %b want 11", {axi_rready, mem_en}); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({axi_rready, mem_en, axi_arvalid} !== 3'b000) begin n_bad++;
            $display("FAIL rst_mid_r got %b want 000", {axi_rready, mem_en, axi_arvalid}); end
        clear_inputs();
        @(negedge clk) rst = 1'b1;
        step();
        n_cmp++; if ({mem_en, axi_arvalid, axi_rready} !== 3'b000) begin n_bad++;
            $display("FAIL rst_after got %b want 000", {mem_en, axi_arvalid, axi_rready}); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte();
        test_store_half();
        test_store_aw_delay();
        test_bus_error();
        test_back_to_back();
        test_misalign();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
